// File: rtl/fight_pkg.sv
// Battle-screen shared types: phase codes, cursor codes, HP width, damage defaults.
// Shared with the renderer; ENEMY_LFSR_EN selects the random enemy skill in fight_ctrl.
package fight_pkg;

  localparam int HP_W  = 8;
  localparam int ST_W  = 6;
  localparam int OPT_W = 4;

  typedef enum logic [ST_W-1:0] {
    ST_MENU     = 6'd1,
    ST_CHOOSE   = 6'd2,
    ST_ANIM_P1  = 6'd3,
    ST_ANIM_P2  = 6'd4,
    ST_DRAIN_P1 = 6'd5,
    ST_DRAIN_P2 = 6'd6,
    ST_OVER     = 6'd7
  } fight_st_e;

  typedef logic [OPT_W-1:0] opt_t;
  typedef logic [HP_W-1:0]  hp_t;

  localparam opt_t OPT_1 = 4'd1;
  localparam opt_t OPT_2 = 4'd2;
  localparam opt_t OPT_3 = 4'd3;
  localparam opt_t OPT_4 = 4'd4;

  localparam int DEF_HP_MAX     = 200;
  localparam int DEF_ANIM_TICKS = 30;
  localparam int DEF_DMG1       = 40;
  localparam int DEF_DMG2       = 25;
  localparam int DEF_DMG3       = 60;
  localparam int DEF_DMG4       = 10;

  typedef struct packed {
    logic enter;
    logic up;
    logic down;
    logic left;
    logic right;
  } keys_t;

  // 2x2 grid: bit1 = row, bit0 = column; pressing toward a reached edge is a no-op
  function automatic opt_t cursor_next(input opt_t cur, input keys_t k);
    logic row;
    logic col;
    row = (cur == OPT_3) || (cur == OPT_4);
    col = (cur == OPT_2) || (cur == OPT_4);
    if (k.up)         row = 1'b0;
    else if (k.down)  row = 1'b1;
    else if (k.left)  col = 1'b0;
    else if (k.right) col = 1'b1;
    return {2'b00, row, col} + OPT_1;
  endfunction

endpackage

// File: rtl/fight_ctrl_hp_drain.sv
// Per-player HP register with pending-damage counter drained one point per tick.
// done is high once the damage is spent or the HP has bottomed out at zero.
module hp_drain
  import fight_pkg::*;
#(
  parameter int HP_MAX = DEF_HP_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic load,
  input  hp_t  dmg_in,
  input  logic en,
  input  logic tick,
  output hp_t  hp,
  output logic done
);

  hp_t hp_q, hp_d;
  hp_t dmg_q, dmg_d;

  assign done = (dmg_q == '0) || (hp_q == '0);
  assign hp   = hp_q;

  always_comb begin
    hp_d  = hp_q;
    dmg_d = dmg_q;
    if (init) begin
      hp_d  = hp_t'(HP_MAX);
      dmg_d = '0;
    end else if (load) begin
      dmg_d = dmg_in;
    end else if (en && tick && !done) begin
      hp_d  = hp_q - 8'd1;
      dmg_d = dmg_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_q  <= hp_t'(HP_MAX);
      dmg_q <= '0;
    end else begin
      hp_q  <= hp_d;
      dmg_q <= dmg_d;
    end
  end

endmodule

// File: rtl/fight_ctrl.sv
// Battle-screen controller: cursor, fight phase, animation pacing and HP drain.
// Define ENEMY_LFSR_EN to pick the enemy skill from an 8-bit LFSR instead of skill 1.
module fight_ctrl
  import fight_pkg::*;
#(
  parameter int HP_MAX     = DEF_HP_MAX,
  parameter int ANIM_TICKS = DEF_ANIM_TICKS,
  parameter int DMG1       = DEF_DMG1,
  parameter int DMG2       = DEF_DMG2,
  parameter int DMG3       = DEF_DMG3,
  parameter int DMG4       = DEF_DMG4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_enter,
  output logic [7:0] p1_cur_hp,
  output logic [7:0] p2_cur_hp,
  output logic [5:0] fight_state,
  output logic [3:0] option_state,
  output logic       fight_over,
  output logic       p1_wins
);

  localparam int CNT_W = $clog2(ANIM_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_TICKS - 1);

  fight_st_e        st_q, st_d;
  opt_t             opt_q, opt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             over_q, over_d;
  logic             win_q, win_d;

  keys_t k;
  logic  anim_end;
  logic  reinit;
  logic  p1_load, p2_load;
  hp_t   ld_dmg;
  hp_t   foe_dmg;
  hp_t   p1_hp, p2_hp;
  logic  p1_done, p2_done;

  function automatic hp_t skill_dmg(input opt_t s);
    hp_t d;
    case (s)
      OPT_2:   d = hp_t'(DMG2);
      OPT_3:   d = hp_t'(DMG3);
      OPT_4:   d = hp_t'(DMG4);
      default: d = hp_t'(DMG1);
    endcase
    return d;
  endfunction

  assign k        = {key_enter, key_up, key_down, key_left, key_right};
  assign anim_end = tick && (cnt_q == CNT_LAST);

`ifdef ENEMY_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  opt_t       foe_q, foe_d;

  // x^8+x^6+x^5+x^4+1, free-running; enemy skill frozen as the attack lands
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    foe_d  = foe_q;
    if (st_q == ST_ANIM_P1 && anim_end)
      foe_d = {2'b00, lfsr_q[1:0]} + OPT_1;
    if (reinit) begin
      lfsr_d = 8'hA5;
      foe_d  = OPT_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
      foe_q  <= OPT_1;
    end else begin
      lfsr_q <= lfsr_d;
      foe_q  <= foe_d;
    end
  end

  assign foe_dmg = skill_dmg(foe_q);
`else
  assign foe_dmg = hp_t'(DMG1);
`endif

  always_comb begin
    st_d    = st_q;
    opt_d   = opt_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    win_d   = win_q;
    reinit  = 1'b0;
    p1_load = 1'b0;
    p2_load = 1'b0;
    ld_dmg  = '0;
    unique case (st_q)
      ST_MENU: begin
        if (k.enter) begin
          if (opt_q == OPT_1) begin
            st_d  = ST_CHOOSE;
            opt_d = OPT_1;
          end
        end else begin
          opt_d = cursor_next(opt_q, k);
        end
      end
      ST_CHOOSE: begin
        if (k.enter) begin
          p2_load = 1'b1;
          ld_dmg  = skill_dmg(opt_q);
          cnt_d   = '0;
          st_d    = ST_ANIM_P1;
        end else begin
          opt_d = cursor_next(opt_q, k);
        end
      end
      ST_ANIM_P1, ST_ANIM_P2: begin
        if (anim_end) begin
          cnt_d = '0;
          st_d  = (st_q == ST_ANIM_P1) ? ST_DRAIN_P2 : ST_DRAIN_P1;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN_P2: begin
        if (p2_done) begin
          if (p2_hp == '0) begin
            st_d   = ST_OVER;
            over_d = 1'b1;
            win_d  = 1'b1;
          end else begin
            p1_load = 1'b1;
            ld_dmg  = foe_dmg;
            cnt_d   = '0;
            st_d    = ST_ANIM_P2;
          end
        end
      end
      ST_DRAIN_P1: begin
        if (p1_done) begin
          if (p1_hp == '0) begin
            st_d   = ST_OVER;
            over_d = 1'b1;
            win_d  = 1'b0;
          end else begin
            st_d  = ST_MENU;
            opt_d = OPT_1;
          end
        end
      end
      ST_OVER: begin
        if (k.enter) begin
          reinit = 1'b1;
          st_d   = ST_MENU;
          opt_d  = OPT_1;
          cnt_d  = '0;
          over_d = 1'b0;
          win_d  = 1'b0;
        end
      end
      default: begin
        st_d  = ST_MENU;
        opt_d = OPT_1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_MENU;
      opt_q  <= OPT_1;
      cnt_q  <= '0;
      over_q <= 1'b0;
      win_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      opt_q  <= opt_d;
      cnt_q  <= cnt_d;
      over_q <= over_d;
      win_q  <= win_d;
    end
  end

  hp_drain #(.HP_MAX(HP_MAX)) u_p1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (reinit),
    .load   (p1_load),
    .dmg_in (ld_dmg),
    .en     (st_q == ST_DRAIN_P1),
    .tick   (tick),
    .hp     (p1_hp),
    .done   (p1_done)
  );

  hp_drain #(.HP_MAX(HP_MAX)) u_p2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (reinit),
    .load   (p2_load),
    .dmg_in (ld_dmg),
    .en     (st_q == ST_DRAIN_P2),
    .tick   (tick),
    .hp     (p2_hp),
    .done   (p2_done)
  );

  assign p1_cur_hp    = p1_hp;
  assign p2_cur_hp    = p2_hp;
  assign fight_state  = st_q;
  assign option_state = opt_q;
  assign fight_over   = over_q;
  assign p1_wins      = win_q;

endmodule

// File: tb/tb_fight_ctrl.sv
// Self-checking bench for fight_ctrl (default build, enemy always skill 1).
// Expected snapshots are queued as stimulus is driven and popped on sampling.
module tb_fight_ctrl;
  import fight_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_enter = 1'b0;
  logic [7:0] p1_cur_hp;
  logic [7:0] p2_cur_hp;
  logic [5:0] fight_state;
  logic [3:0] option_state;
  logic       fight_over;
  logic       p1_wins;

  typedef struct packed {
    logic [5:0] st;
    logic [3:0] opt;
    logic [7:0] p1;
    logic [7:0] p2;
    logic       over;
    logic       win;
  } snap_t;

  snap_t sb[$];
  snap_t e;
  int n_chk = 0;
  int n_fail = 0;

  fight_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_enter    (key_enter),
    .p1_cur_hp    (p1_cur_hp),
    .p2_cur_hp    (p2_cur_hp),
    .fight_state  (fight_state),
    .option_state (option_state),
    .fight_over   (fight_over),
    .p1_wins      (p1_wins)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input int st, input int opt, input int p1,
                               input int p2, input bit ov, input bit w);
    snap_t s;
    s.st = 6'(st);
    s.opt = 4'(opt);
    s.p1 = 8'(p1);
    s.p2 = 8'(p2);
    s.over = ov;
    s.win = w;
    return s;
  endfunction

  function snap_t obs();
    snap_t s;
    s.st = fight_state;
    s.opt = option_state;
    s.p1 = p1_cur_hp;
    s.p2 = p2_cur_hp;
    s.over = fight_over;
    s.win = p1_wins;
    return s;
  endfunction

  // keys packed as {enter, up, down, left, right}
  task automatic press(input logic [4:0] kv);
    @(negedge clk);
    {key_enter, key_up, key_down, key_left, key_right} = kv;
    @(negedge clk);
    {key_enter, key_up, key_down, key_left, key_right} = 5'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {key_enter, key_up, key_down, key_left, key_right} = 5'b0;
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sb.push_back(mk(1, 1, 200, 200, 0, 0));
    do_reset();
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_cursor();
    logic [4:0] kv[13] = '{5'b00001, 5'b00100, 5'b00001, 5'b00100,
                           5'b00010, 5'b01000, 5'b01000, 5'b00010,
                           5'b00101, 5'b10000, 5'b01100, 5'b10001,
                           5'b00001};
    int st_x[13]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
    int opt_x[13] = '{2, 4, 4, 4, 3, 1, 1, 1, 3, 3, 1, 1, 2};
    do_reset();
    for (int i = 0; i < 13; i++)
      sb.push_back(mk(st_x[i], opt_x[i], 200, 200, 0, 0));
    for (int i = 0; i < 13; i++) begin
      press(kv[i]);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL cursor step %0d got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_round();
    int n[7] = '{29, 1, 40, 0, 30, 40, 0};
    do_reset();
    sb.push_back(mk(3, 1, 200, 200, 0, 0));
    sb.push_back(mk(6, 1, 200, 200, 0, 0));
    sb.push_back(mk(6, 1, 200, 160, 0, 0));
    sb.push_back(mk(4, 1, 200, 160, 0, 0));
    sb.push_back(mk(5, 1, 200, 160, 0, 0));
    sb.push_back(mk(5, 1, 160, 160, 0, 0));
    sb.push_back(mk(1, 1, 160, 160, 0, 0));
    press(5'b10000);
    press(5'b10000);
    for (int i = 0; i < 7; i++) begin
      if (n[i] == 0) @(negedge clk);
      else ticks(n[i]);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL round step %0d got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_to_over();
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      sb.push_back(mk(1, 1, 200 - 40 * r, 200 - 60 * r, 0, 0));
      press(5'b10000);
      press(5'b00100);
      press(5'b10000);
      ticks(30);
      ticks(60);
      @(negedge clk);
      ticks(30);
      ticks(40);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL skill3 round %0d got %h exp %h", r, obs(), e);
      end
    end
    sb.push_back(mk(6, 3, 80, 0, 0, 0));
    sb.push_back(mk(7, 3, 80, 0, 1, 1));
    sb.push_back(mk(1, 1, 200, 200, 0, 0));
    press(5'b10000);
    press(5'b00100);
    press(5'b10000);
    ticks(30);
    ticks(20);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) @(negedge clk);
      if (i == 2) press(5'b10000);
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL over step %0d got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    sb.push_back(mk(6, 1, 200, 175, 0, 0));
    sb.push_back(mk(1, 1, 200, 200, 0, 0));
    press(5'b10000);
    press(5'b10000);
    ticks(30);
    ticks(25);
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL mid_drain got %h exp %h", obs(), e);
    end
    #2 rst_n = 1'b0;
    #1;
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL async_reset got %h exp %h", obs(), e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cursor();
    test_round();
    test_to_over();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
